// File: rtl/axis_out_packer_if.sv
// Pixel-in / AXI-Stream-out bundle for the output packer.
// master = packer side, slave = core + downstream side.
interface axis_out_packer_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  modport master (
    input  pix_valid, pix_data, m_axis_tready,
    output pix_ready, m_axis_tvalid, m_axis_tdata,
    output m_axis_tstrb, m_axis_tlast
  );

  modport slave (
    output pix_valid, pix_data, m_axis_tready,
    input  pix_ready, m_axis_tvalid, m_axis_tdata,
    input  m_axis_tstrb, m_axis_tlast
  );
endinterface

// File: rtl/axis_out_packer.sv
// Packs pixel bytes little-endian into 32-bit AXI-Stream words
// through a 2-entry output FIFO, framed by start/flush/tlast.
module axis_out_packer #(
  parameter int FRAME_WORDS = 576
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic flush,
  output logic busy,
  output logic done,
  axis_out_packer_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        fpend_q, fpend_d;
  logic        done_q, done_d;

  logic [31:0] dat_q [2];
  logic [3:0]  stb_q [2];
  logic        lst_q [2];
  logic        rd_q, wr_q;
  logic [1:0]  cnt_q;

  logic        run, pop, accept, free_slot;
  logic        flush_req, push, mark;
  logic [1:0]  cnt_pop;
  logic [31:0] push_dat;
  logic [3:0]  push_stb;
  logic        push_lst;

  assign run       = state_q == S_RUN;
  assign pop       = bus.m_axis_tvalid && bus.m_axis_tready;
  assign cnt_pop   = cnt_q - {1'b0, pop};
  assign free_slot = cnt_pop != 2'd2;
  assign flush_req = run && !start && (flush || fpend_q);

  assign bus.pix_ready = run && !start && !fpend_q &&
                         (lane_q != 2'd3 || free_slot);
  assign accept = bus.pix_valid && bus.pix_ready;

  assign bus.m_axis_tvalid = cnt_q != 2'd0;
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? dat_q[rd_q] : '0;
  assign bus.m_axis_tstrb  = bus.m_axis_tvalid ? stb_q[rd_q] : '0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && lst_q[rd_q];

  assign busy = state_q != S_IDLE;
  assign done = done_q;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    fpend_d  = fpend_q;
    done_d   = 1'b0;
    push     = 1'b0;
    mark     = 1'b0;
    push_dat = '0;
    push_stb = '0;
    push_lst = 1'b0;

    if (accept) begin
      lane_d = lane_q + 2'd1;
      unique case (lane_q)
        2'd0: acc_d[7:0]   = bus.pix_data;
        2'd1: acc_d[15:8]  = bus.pix_data;
        2'd2: acc_d[23:16] = bus.pix_data;
        default: begin
          push     = 1'b1;
          push_dat = {bus.pix_data, acc_q};
          push_stb = 4'hF;
          push_lst = wcnt_q == LAST_IDX;
          acc_d    = '0;
        end
      endcase
    end

    if (flush_req) begin
      fpend_d = 1'b0;
      if (push) begin
        push_lst = 1'b1;
      end else if (lane_d != 2'd0) begin
        // A partial word waits here if the FIFO has no room yet.
        if (free_slot) begin
          push     = 1'b1;
          push_dat = {8'h00, acc_d};
          push_lst = 1'b1;
          unique case (lane_d)
            2'd1:    push_stb = 4'b0001;
            2'd2:    push_stb = 4'b0011;
            default: push_stb = 4'b0111;
          endcase
          lane_d = 2'd0;
          acc_d  = '0;
        end else begin
          fpend_d = 1'b1;
        end
      end else if (wcnt_q != 16'd0) begin
        if (cnt_pop != 2'd0) begin
          mark = 1'b1;
        end else begin
          push     = 1'b1;
          push_lst = 1'b1;
        end
      end
    end

    if (push) wcnt_d = wcnt_q + 16'd1;
    if (run && ((push && push_lst) || mark)) state_d = S_DRAIN;

    if (state_q == S_DRAIN && pop && bus.m_axis_tlast) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end

    if (start) begin
      state_d = S_RUN;
      lane_d  = 2'd0;
      acc_d   = '0;
      wcnt_d  = '0;
      fpend_d = 1'b0;
      done_d  = 1'b0;
      push    = 1'b0;
      mark    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      fpend_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      fpend_q <= fpend_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        dat_q[i] <= '0;
        stb_q[i] <= '0;
        lst_q[i] <= 1'b0;
      end
    end else if (start) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        dat_q[wr_q] <= push_dat;
        stb_q[wr_q] <= push_stb;
        lst_q[wr_q] <= push_lst;
        wr_q        <= ~wr_q;
      end
      // The newest entry always sits just behind the write pointer.
      if (mark) lst_q[~wr_q] <= 1'b1;
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_axis_out_packer.sv
// Bench for axis_out_packer: flush vectors, hand sequences and
// random backpressure runs checked against a byte-queue model.
module tb_axis_out_packer;

  localparam int FW = 576;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } word_t;

  typedef struct {
    int          n;
    logic [31:0] pat;
    bit          fl;
    logic [31:0] ed;
    logic [3:0]  es;
  } vec_t;

  logic clk, rstn, start, flush, busy, done;
  logic rdy_set, bp_mode;
  int   total = 0;
  int   bad = 0;
  int   st;

  logic [7:0] bytes[$];
  word_t      got[$];
  vec_t       vecs[5];

  logic        prev_hs_last, prev_stall, prev_start;
  logic [31:0] prev_d;
  logic [3:0]  prev_s;

  axis_out_packer_if bus();

  axis_out_packer #(.FRAME_WORDS(FW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bp_mode) bus.m_axis_tready = ~bus.m_axis_tready;
    else bus.m_axis_tready = rdy_set;
  end

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      prev_hs_last = 1'b0;
      prev_stall   = 1'b0;
      prev_start   = 1'b0;
    end else begin
      chk("done pulse", done, prev_hs_last);
      if (prev_stall && !prev_start) begin
        chk("stall tvalid", bus.m_axis_tvalid, 1);
        chk("stall tdata", bus.m_axis_tdata, prev_d);
        chk("stall tstrb", bus.m_axis_tstrb, prev_s);
      end
      if (bytes.size() % 4 == 3 && !bus.m_axis_tready &&
          (bytes.size() / 4 - got.size()) == 2)
        chk("ready gate", bus.pix_ready, 0);
      if (bus.pix_valid && bus.pix_ready)
        bytes.push_back(bus.pix_data);
      if (bus.m_axis_tvalid && bus.m_axis_tready)
        got.push_back({bus.m_axis_tdata, bus.m_axis_tstrb,
                       bus.m_axis_tlast});
      prev_hs_last = bus.m_axis_tvalid && bus.m_axis_tready &&
                     bus.m_axis_tlast;
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_d     = bus.m_axis_tdata;
      prev_s     = bus.m_axis_tstrb;
      prev_start = start;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    bytes.delete();
    got.delete();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic feed(input int n, input int pct, input bit fl,
                      input logic [31:0] pat, input bit use_pat,
                      output int stalls);
    int nacc = 0;
    int cyc = 0;
    stalls = 0;
    while (nacc < n && cyc < 20000) begin
      bus.pix_valid = $urandom_range(99) < pct;
      bus.pix_data  = use_pat ? 8'(pat >> (8 * nacc)) : 8'(nacc);
      flush = fl && bus.pix_valid && (nacc == n - 1);
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) nacc++;
      else if (bus.pix_valid) stalls++;
      cyc++;
      step();
    end
    bus.pix_valid = 1'b0;
    flush = 1'b0;
    chk("feed count", nacc, n);
  endtask

  task automatic wait_done(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done seen", seen, 1);
    step();
  endtask

  task automatic check_frame(input int nw);
    logic [31:0] ew;
    chk("frame words", got.size(), nw);
    for (int k = 0; k < got.size() && k < nw; k++) begin
      ew = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
      chk("frame data", got[k].d, ew);
      chk("frame strb", got[k].s, 4'hF);
      chk("frame last", got[k].l, k == nw - 1);
    end
  endtask

  initial begin
    vecs[0] = '{2, 32'h0000BBAA, 1'b0, 32'h0000BBAA, 4'b0011};
    vecs[1] = '{1, 32'h00000011, 1'b0, 32'h00000011, 4'b0001};
    vecs[2] = '{3, 32'h00332211, 1'b0, 32'h00332211, 4'b0111};
    vecs[3] = '{4, 32'hDDCCBBAA, 1'b1, 32'hDDCCBBAA, 4'b1111};
    vecs[4] = '{3, 32'h00FE0180, 1'b0, 32'h00FE0180, 4'b0111};

    rstn = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    rdy_set = 1'b1;
    bp_mode = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.m_axis_tready = 1'b1;

    #12;
    chk("rst tvalid", bus.m_axis_tvalid, 0);
    chk("rst tdata", bus.m_axis_tdata, 0);
    chk("rst tstrb", bus.m_axis_tstrb, 0);
    chk("rst tlast", bus.m_axis_tlast, 0);
    chk("rst pix_ready", bus.pix_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    step();
    rstn = 1'b1;
    bus.pix_valid = 1'b1;
    repeat (3) step();
    chk("idle pix_ready", bus.pix_ready, 0);
    chk("idle busy", busy, 0);
    chk("idle tvalid", bus.m_axis_tvalid, 0);
    bus.pix_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_start();
      chk("vec busy", busy, 1);
      feed(vecs[i].n, 100, vecs[i].fl, vecs[i].pat, 1, st);
      if (!vecs[i].fl) pulse_flush();
      wait_done(20);
      chk("vec words", got.size(), 1);
      if (got.size() > 0) begin
        chk("vec tdata", got[0].d, vecs[i].ed);
        chk("vec tstrb", got[0].s, vecs[i].es);
        chk("vec tlast", got[0].l, 1);
      end
      chk("vec idle", busy, 0);
    end

    do_start();
    pulse_flush();
    repeat (3) step();
    chk("empty flush tvalid", bus.m_axis_tvalid, 0);
    chk("empty flush busy", busy, 1);
    feed(4, 100, 0, 32'h04030201, 1, st);
    chk("latency tvalid", bus.m_axis_tvalid, 1);
    repeat (3) step();
    pulse_flush();
    wait_done(20);
    chk("zero words", got.size(), 2);
    if (got.size() == 2) begin
      chk("zero w0 data", got[0].d, 32'h04030201);
      chk("zero w0 last", got[0].l, 0);
      chk("zero w1 data", got[1].d, 0);
      chk("zero w1 strb", got[1].s, 0);
      chk("zero w1 last", got[1].l, 1);
    end

    rdy_set = 1'b0;
    do_start();
    step();
    feed(4, 100, 0, 32'h0D0C0B0A, 1, st);
    chk("mark tvalid", bus.m_axis_tvalid, 1);
    chk("mark pre tlast", bus.m_axis_tlast, 0);
    pulse_flush();
    chk("mark tlast", bus.m_axis_tlast, 1);
    chk("mark busy", busy, 1);
    rdy_set = 1'b1;
    wait_done(20);
    chk("mark words", got.size(), 1);
    if (got.size() == 1) begin
      chk("mark data", got[0].d, 32'h0D0C0B0A);
      chk("mark last", got[0].l, 1);
    end

    do_start();
    feed(400, 100, 0, 0, 0, st);
    step();
    rdy_set = 1'b0;
    step();
    feed(8, 100, 0, 0, 0, st);
    chk("restart popped", got.size(), 100);
    chk("restart queued", bus.m_axis_tvalid, 1);
    do_start();
    chk("restart tvalid", bus.m_axis_tvalid, 0);
    rdy_set = 1'b1;
    step();
    feed(FW * 4, 100, 0, 0, 0, st);
    chk("no gaps", st, 0);
    wait_done(20);
    check_frame(FW);
    if (got.size() > 1) begin
      chk("word0", got[0].d, 32'h03020100);
      chk("word1", got[1].d, 32'h07060504);
    end

    do_start();
    bp_mode = 1'b1;
    feed(FW * 4, 60, 0, 0, 0, st);
    wait_done(50);
    bp_mode = 1'b0;
    check_frame(FW);

    rdy_set = 1'b0;
    step();
    step();
    do_start();
    feed(11, 100, 0, 0, 0, st);
    chk("pre rst tvalid", bus.m_axis_tvalid, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid rst tvalid", bus.m_axis_tvalid, 0);
    chk("mid rst pix_ready", bus.pix_ready, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst tdata", bus.m_axis_tdata, 0);
    rdy_set = 1'b1;
    bus.pix_valid = 1'b1;
    step();
    rstn = 1'b1;
    got.delete();
    bytes.delete();
    repeat (5) step();
    chk("post rst tvalid", bus.m_axis_tvalid, 0);
    chk("post rst pix_ready", bus.pix_ready, 0);
    chk("post rst busy", busy, 0);
    chk("post rst words", got.size(), 0);
    bus.pix_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_out_packer.md
AXIS_OUT_PACKER -- requirements
Module: axis_out_packer

Interface
REQ-001 The block SHALL have parameter FRAME_WORDS, default 576, giving the number of 32-bit words per output frame; the legal range is 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle pulse that clears all state and arms a new frame.
REQ-005 The block SHALL have port pix_valid, input, 1 bit: a pixel byte is offered by the compute core.
REQ-006 The block SHALL have port pix_data, input, 8 bits: the pixel byte.
REQ-007 The block SHALL have port pix_ready, output, 1 bit: the packer accepts a pixel when pix_valid and pix_ready are both high.
REQ-008 The block SHALL have port flush, input, 1 bit: one-cycle pulse that closes a partial word as the frame end.
REQ-009 The block SHALL have port m_axis_tvalid, output, 1 bit: AXI-Stream master valid.
REQ-010 The block SHALL have port m_axis_tdata, output, 32 bits: packed word.
REQ-011 The block SHALL have port m_axis_tstrb, output, 4 bits: byte-lane strobe.
REQ-012 The block SHALL have port m_axis_tlast, output, 1 bit: last word of the frame.
REQ-013 The block SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-014 The block SHALL have port busy, output, 1 bit: high from start until the tlast handshake.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse on the cycle after the tlast handshake.

Function
REQ-016 The block SHALL pack bytes little-endian: the first accepted byte goes to [7:0], the second to [15:8], the third to [23:16], the fourth to [31:24].
- A 2-bit lane counter tracks the byte position and wraps from 3 to 0 when a word completes.
REQ-017 A completed word SHALL be pushed into a 2-entry output FIFO on the cycle after its 4th byte is accepted.
- tstrb = 4'hF.
- tlast is set when the word index equals FRAME_WORDS-1.
REQ-018 pix_ready SHALL be high only when all of the following hold:
- busy is high;
- the frame is not yet complete;
- if lane=3, the FIFO has a free slot after this cycle's pop.
REQ-019 m_axis_tvalid SHALL equal "FIFO not empty", and the FIFO head SHALL drive tdata, tstrb and tlast.
- The FIFO pops on the tvalid&&tready handshake.
- tdata, tstrb and tlast SHALL hold stable while tvalid is high and tready is low.
REQ-020 A simultaneous FIFO push and pop SHALL be legal at any occupancy.
- A push while full SHALL never occur: pix_ready gating guarantees this.
REQ-021 A 16-bit word counter SHALL increment on each push; after the push with index FRAME_WORDS-1, pix_ready SHALL stay low until the next start.
REQ-022 A flush with lane>0 SHALL push the partial word with the following fields:
- unfilled bytes = 0;
- tstrb bit n = 1 only for filled lanes;
- tlast = 1.
The frame then ends.
REQ-023 A flush with lane=0 and at least one word already pushed SHALL set tlast on the most recent word if that word is still in the FIFO; otherwise it SHALL push a zero word with tstrb=0 and tlast=1.
REQ-024 A flush with no word pushed and lane=0 SHALL be ignored.
REQ-025 If flush and a 4th-byte acceptance occur in the same cycle, the full word SHALL be pushed with tlast=1.
REQ-026 The state machine SHALL have three states:
- IDLE to RUN on start.
- RUN to DRAIN on a last-word push.
- DRAIN to IDLE on the tlast handshake, which pulses done.
REQ-027 busy SHALL be high in RUN and DRAIN.
REQ-028 start in any state SHALL do all of the following:
- empty the FIFO;
- zero the lane counter and word counter;
- drop tvalid on the next cycle;
- enter RUN.
An in-flight frame is discarded without tlast.
REQ-029 Latency from the 4th-byte acceptance to tvalid SHALL be 1 cycle when the FIFO is empty.
REQ-030 Sustained throughput SHALL be 1 byte/cycle with tready held high, with no bubbles at word boundaries.

Reset
REQ-031 While rstn=0, the block SHALL hold the following asynchronously:
- state IDLE;
- FIFO empty;
- lane=0, word count=0;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0;
- pix_ready=0, busy=0, done=0.
REQ-032 After rstn rises, outputs SHALL stay at their reset values until start.
REQ-033 Reset asserted mid-frame SHALL discard all data with no partial output.

Verification
REQ-034 With FRAME_WORDS=576, tready=1, start, then bytes 0..255 repeating continuously for 2304 bytes:
- word 0 = 32'h03020100, word 1 = 32'h07060504;
- tlast only on word 575;
- done 1 cycle after word 575;
- no gaps in pix_ready.
REQ-035 Backpressure case: tready toggling 1/0 every cycle and random pix_valid SHALL give the same word sequence, with tdata held stable while stalled and pix_ready low whenever lane=3 and the FIFO is full.
REQ-036 Bytes AA, BB, then flush SHALL produce tdata=32'h0000BBAA, tstrb=4'b0011, tlast=1, then done.
REQ-037 start asserted after 100 words with 2 words queued and tready=0 SHALL give tvalid=0 on the next cycle; a new frame SHALL then restart at word 0 with a correct tlast.
REQ-038 rstn pulsed low mid-frame SHALL immediately give tvalid=0, pix_ready=0, busy=0, with no output until the next start.
